// File: rtl/bk_adder_pipe.sv
// rtl/bk_adder_pipe.sv - 3-stage pipelined Brent-Kung adder/subtractor with valid/ready handshake
//
// Purpose:
//   Adds or subtracts two WIDTH-bit operands through a Brent-Kung parallel
//   prefix carry network that is split over three register stages:
//     stage 1 : operand conditioning, bitwise generate/propagate
//     stage 2 : up-sweep of the prefix tree (LOG2W merge levels)
//     stage 3 : down-sweep (LOG2W-1 levels), carries, sum, cout, ovf
//   One global advance signal moves the whole pipeline, so a stalled output
//   holds every stage in place.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operands valid this cycle
//   in_ready   pipeline can accept operands this cycle
//   a, b       operands, WIDTH bits
//   cin        carry-in, ignored when sub=1
//   sub        0: a+b+cin, 1: a-b (a+~b+1)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (for sub: 1 means no borrow)
//   ovf        two's-complement overflow

module bk_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int LOG2W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // The prefix tree shape depends on WIDTH being exactly 2^LOG2W.
    generate
        if (WIDTH < 4 || (1 << LOG2W) != WIDTH) begin : g_param_check
            $error("bk_adder_pipe: WIDTH must be a power of two >= 4 and equal 2**LOG2W");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake: a single advance moves every stage together. The output
    // register is free when it is empty or being consumed this cycle.
    // ------------------------------------------------------------------
    logic advance;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ------------------------------------------------------------------
    // Stage 1: operand conditioning and bitwise generate/propagate
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : cin;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic             s1_c0;
    logic             s1_a_msb;
    logic             s1_b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_c0    <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid & in_ready;
            s1_g     <= a & b_eff;
            s1_p     <= a ^ b_eff;
            s1_c0    <= c0;
            s1_a_msb <= a[WIDTH-1];
            s1_b_msb <= b_eff[WIDTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: up-sweep. At level k, node j with (j+1) a multiple of 2^k
    // absorbs the group ending at j-2^(k-1). Updating in place is safe:
    // the partner node is never itself a target at the same level.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] up_g;
    logic [WIDTH-1:0] up_p;

    always_comb begin
        up_g = s1_g;
        up_p = s1_p;
        for (int k = 1; k <= LOG2W; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (((j + 1) % (1 << k)) == 0) begin
                    // group generate uses the high group's propagate before it narrows
                    up_g[j] = up_g[j] | (up_p[j] & up_g[j - (1 << (k - 1))]);
                    up_p[j] = up_p[j] & up_p[j - (1 << (k - 1))];
                end
            end
        end
    end

    logic             s2_valid;
    logic [WIDTH-1:0] s2_gg;
    logic [WIDTH-1:0] s2_gp;
    logic [WIDTH-1:0] s2_p;
    logic             s2_c0;
    logic             s2_a_msb;
    logic             s2_b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_gg    <= '0;
            s2_gp    <= '0;
            s2_p     <= '0;
            s2_c0    <= 1'b0;
            s2_a_msb <= 1'b0;
            s2_b_msb <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_gg    <= up_g;
            s2_gp    <= up_p;
            s2_p     <= s1_p;
            s2_c0    <= s1_c0;
            s2_a_msb <= s1_a_msb;
            s2_b_msb <= s1_b_msb;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: down-sweep. After the up-sweep every node 2^m-1 holds the
    // full prefix [j:0]. Walking levels downwards, node j = m*2^k+2^(k-1)-1
    // (m >= 1) combines with the complete prefix at j-2^(k-1), filling in
    // the remaining positions.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] dn_g;
    logic [WIDTH-1:0] dn_p;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;

    always_comb begin
        dn_g = s2_gg;
        dn_p = s2_gp;
        for (int k = LOG2W - 1; k >= 1; k--) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (j >= (1 << k) && ((j + 1) % (1 << k)) == (1 << (k - 1))) begin
                    dn_g[j] = dn_g[j] | (dn_p[j] & dn_g[j - (1 << (k - 1))]);
                    dn_p[j] = dn_p[j] & dn_p[j - (1 << (k - 1))];
                end
            end
        end

        // carry into bit i+1 is the prefix [i:0] folded with the carry-in
        carry[0] = s2_c0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i + 1] = dn_g[i] | (dn_p[i] & s2_c0);
        end

        sum_next  = s2_p ^ carry[WIDTH-1:0];
        cout_next = carry[WIDTH];
        // Same-sign operands producing an opposite-sign result; this is
        // identical to carry[WIDTH] ^ carry[WIDTH-1] but reuses the stored
        // operand sign bits instead of another carry term.
        ovf_next  = (s2_a_msb ~^ s2_b_msb) & (s2_a_msb ^ sum_next[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            sum       <= sum_next;
            cout      <= cout_next;
            ovf       <= ovf_next;
        end
    end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// tb/tb_bk_adder_pipe.sv - self-checking bench for bk_adder_pipe with a behavioural arithmetic model

module tb_bk_adder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    bk_adder_pipe #(.WIDTH(16), .LOG2W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    // {ovf, cout, sum} from plain integer arithmetic on the operands
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
        int ux, uy, sx, sy, u, r;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            u  = ux - uy;
            r  = sx - sy;
            co = (ux >= uy);
        end else begin
            u  = ux + uy + int'(ci);
            r  = sx + sy + int'(ci);
            co = (u > 65535);
        end
        ov = (r > 32767) || (r < -32768);
        return {ov, co, u[15:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++;
        if ({ovf, cout, sum} !== 18'h0) begin bad++; $display("FAIL reset_data: got %h want 0", {ovf, cout, sum}); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] vb [5] = '{16'h0FED, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic        vc [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] ve [5] = '{{2'b00, 16'h2222}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                                {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};
        int lat;
        for (int n = 0; n < 5; n++) begin
            out_ready = 1'b1;
            in_valid = 1'b1;
            a = va[n]; b = vb[n]; cin = vc[n]; sub = vs[n];
            @(negedge clk);
            in_valid = 1'b0;
            a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            total++;
            if (lat !== 3) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want 3", n, lat); end
            total++;
            if ({ovf, cout, sum} !== ve[n]) begin
                bad++;
                $display("FAIL directed_result[%0d]: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                         n, ovf, cout, sum, ve[n][17], ve[n][16], ve[n][15:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int first = -1;
        int last = -1;
        logic [17:0] e;
        exp_q.delete();
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = 1'b1;
            in_valid = (cyc < 20);
            a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", cyc, in_ready); end
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                got++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_spurious[%0d]: got sum=%h want no result", cyc, sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        bad++;
                        $display("FAIL b2b_result[%0d]: got %h want %h", cyc, {ovf, cout, sum}, e);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (got !== 20) begin bad++; $display("FAIL b2b_count: got %0d want 20", got); end
        total++;
        if (first !== 3) begin bad++; $display("FAIL b2b_first_cycle: got %0d want 3", first); end
        total++;
        if (last - first !== 19) begin bad++; $display("FAIL b2b_contiguous: got span %0d want 19", last - first); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic hold = 1'b0;
        logic [17:0] held = '0;
        logic [17:0] e;
        logic [15:0] ca, cb;
        logic cc, cs;
        ca = $urandom; cb = $urandom; cc = $urandom; cs = $urandom;
        exp_q.delete();
        while (got < 8 && cyc < 200) begin
            out_ready = ((cyc % 3) == 0);
            in_valid = (sent < 8);
            a = ca; b = cb; cin = cc; sub = cs;
            #1;
            total++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                bad++;
                $display("FAIL bp_in_ready[%0d]: got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
            end
            if (hold) begin
                total++;
                if (out_valid !== 1'b1 || {ovf, cout, sum} !== held) begin
                    bad++;
                    $display("FAIL bp_stable[%0d]: got v=%b %h want v=1 %h", cyc, out_valid, {ovf, cout, sum}, held);
                end
            end
            if (out_valid && out_ready) begin
                got++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_spurious[%0d]: got %h want no result", cyc, {ovf, cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        bad++;
                        $display("FAIL bp_result[%0d]: got %h want %h", cyc, {ovf, cout, sum}, e);
                    end
                end
            end
            hold = out_valid && !out_ready;
            held = {ovf, cout, sum};
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
                ca = $urandom; cb = $urandom; cc = $urandom; cs = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got !== 8 || sent !== 8 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL bp_count: got recv=%0d sent=%0d left=%0d want 8 8 0", got, sent, exp_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_duplicate[%0d]: got out_valid=%b want 0", i, out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_inflight();
        logic [17:0] e;
        int lat;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_immediate: got out_valid=%b want 0", out_valid); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stale[%0d]: got out_valid=%b want 0", i, out_valid); end
        end
        in_valid = 1'b1;
        a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
        e = model(a, b, cin, sub);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL rst_next_latency: got %0d want 3", lat); end
        total++;
        if ({ovf, cout, sum} !== e) begin bad++; $display("FAIL rst_next_result: got %h want %h", {ovf, cout, sum}, e); end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
